// File: rtl/alu_driver.sv
// -----------------------------------------------------------------------------
// alu_driver
//   Command-side front end for the 4-bit ALU. Accepts one tagged operation at a
//   time over a valid/ready handshake, drives the ALU operands and holds them
//   stable, waits out the ALU's registered latency, captures y/carry and
//   returns a tagged response over a second valid/ready handshake.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   cmd_valid/cmd_ready      command handshake
//   cmd_op/cmd_a/cmd_b/cmd_tag  command payload (op: 00 add 01 sub 10 and 11 or)
//   alu_op/alu_a/alu_b       operands driven to the ALU (held between commands)
//   alu_y/alu_carry          ALU result inputs
//   rsp_valid/rsp_ready      response handshake
//   rsp_y/rsp_carry/rsp_tag  captured result and echoed tag
//   rsp_mismatch             self-check flag (0 unless ALU_DRV_CHECK_EN)
//   busy                     high whenever not IDLE
//   done_cnt                 wrapping count of completed responses
//
// Build option:
//   ALU_DRV_CHECK_EN  when defined, an internal reference model predicts the
//                     5-bit result at accept and rsp_mismatch flags a
//                     disagreement with the captured ALU output.
// -----------------------------------------------------------------------------
module alu_driver #(
    parameter int LATENCY = 2,
    parameter int TAG_W   = 4,
    parameter int CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [3:0]       cmd_a,
    input  logic [3:0]       cmd_b,
    input  logic [TAG_W-1:0] cmd_tag,
    output logic [1:0]       alu_op,
    output logic [3:0]       alu_a,
    output logic [3:0]       alu_b,
    input  logic [3:0]       alu_y,
    input  logic             alu_carry,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [3:0]       rsp_y,
    output logic             rsp_carry,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             rsp_mismatch,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       wait_cnt;
    logic [TAG_W-1:0] tag_lat;
    logic             wait_done;

    assign wait_done = (wait_cnt == 4'd0);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                busy      = 1'b0;
                if (cmd_valid) state_nxt = WAIT;
            end
            WAIT: begin
                if (wait_done) state_nxt = RESP;
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand launch, latency countdown, result capture and completion count.
    // The counter is loaded with LATENCY at accept and the capture happens on
    // the edge where it reads zero, i.e. LATENCY+1 edges after accept.
    always_ff @(posedge clk) begin
        if (rst) begin
            alu_op    <= 2'd0;
            alu_a     <= 4'd0;
            alu_b     <= 4'd0;
            wait_cnt  <= 4'd0;
            tag_lat   <= '0;
            rsp_y     <= 4'd0;
            rsp_carry <= 1'b0;
            rsp_tag   <= '0;
            done_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        alu_op   <= cmd_op;
                        alu_a    <= cmd_a;
                        alu_b    <= cmd_b;
                        tag_lat  <= cmd_tag;
                        wait_cnt <= 4'(LATENCY);
                    end
                end
                WAIT: begin
                    if (wait_done) begin
                        rsp_y     <= alu_y;
                        rsp_carry <= alu_carry;
                        rsp_tag   <= tag_lat;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready) done_cnt <= done_cnt + CNT_W'(1);
                end
                default: ;
            endcase
        end
    end

`ifdef ALU_DRV_CHECK_EN
    logic [4:0] exp_res;
    logic       mismatch_r;

    // Reference result: bit 4 is carry for add, borrow (a<b) for sub, 0 for logic ops.
    function automatic logic [4:0] ref_result(input logic [1:0] op,
                                              input logic [3:0] a,
                                              input logic [3:0] b);
        logic [4:0] r;
        case (op)
            2'b00:   r = {1'b0, a} + {1'b0, b};
            2'b01:   r = {1'b0, a} - {1'b0, b};
            2'b10:   r = {1'b0, a & b};
            default: r = {1'b0, a | b};
        endcase
        return r;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_res    <= 5'd0;
            mismatch_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) exp_res <= ref_result(cmd_op, cmd_a, cmd_b);
                WAIT: if (wait_done) mismatch_r <= ({alu_carry, alu_y} != exp_res);
                RESP: if (rsp_ready) mismatch_r <= 1'b0;
                default: ;
            endcase
        end
    end

    assign rsp_mismatch = mismatch_r;
`else
    assign rsp_mismatch = 1'b0;
`endif

endmodule
